rom_dl_ctrl: RTL
================

// Module: rom_dl_ctrl
// PURPOSE
//  Sits between hps_io's ioctl download bus and sdram/target_top. Packs ROM bytes into 16-bit words.
//  Issues toggle-handshake write requests: port1 gets the full ROM, port2 mirrors the sprite region.
//  Routes PROM bytes to target_top's dl_* bus and latches the core-mod byte and DIP bytes.
//  Generates the core reset, released only after a complete download.
// PARAMETERS
//  SPR_BASE    25'h30000  first byte address mirrored to port2 (port2 addr = addr-SPR_BASE)
//  PROM_BASE   25'hA0000  first byte address routed to dl_* (not written to SDRAM)
//  RST_CYCLES  16'hFFFF   core reset hold time in clk_sys cycles after last reset cause
// PORTS
//  clk_sys         in   1   system clock
//  reset           in   1   synchronous, active-high
//  ioctl_download  in   1   download active
//  ioctl_index     in   8   0=ROM, 1=core mod, 254=DIP
//  ioctl_wr        in   1   byte strobe (level; rising edge = one byte)
//  ioctl_addr      in   25  byte address
//  ioctl_dout      in   8   byte data
//  ioctl_wait      out  1   high while any issued request is unacked
//  port1_req       out  1   toggle; new request when != port1_ack
//  port1_ack       in   1   toggle from sdram
//  port1_a         out  23  word address
//  port1_ds        out  2   byte enables {hi,lo}
//  port1_d         out  16  write data, even byte in [7:0]
//  port2_req/ack/a/ds/d     as port1, sprite region only
//  dl_addr         out  16  PROM byte address (addr-PROM_BASE)
//  dl_data         out  8   PROM byte
//  dl_wr           out  1   one-cycle PROM write pulse
//  core_mod        out  8   last byte written with index 1
//  dsw             out  64  DIP bytes 0..7 (index 254, addr<8), byte n at [8n+7:8n]
//  rom_loaded      out  1   sticky; set on falling edge of ioctl_download with index 0
//  core_reset      out  1   reset to target_top
// BEHAVIOUR
//  - Reset: req toggles 0, a/ds/d 0, ioctl_wait 0, dl_wr 0, core_mod 0, dsw all 1s, rom_loaded 0,
//    core_reset 1, pending-byte flag clear, FSM IDLE.
//  - Byte accepted on ioctl_wr rising edge (registered edge detect) when index 0 and addr < PROM_BASE.
//  - Even addr: byte held in lo reg with word addr, pending=1; no request.
//  - Odd addr matching pending word: issue {hi,lo}, ds=11.
//  - Odd addr with no matching pending: flush pending (if any, ds=01) first, then issue hi alone, ds=10.
//  - Even addr while pending set: flush old pending (ds=01), then hold new byte.
//  - Download end (ioctl_download 1->0) with pending: flush ds=01 before rom_loaded sets.
//  - Issue: a/ds/d registered same cycle req toggles; port2 toggles too iff SPR_BASE<=addr<PROM_BASE.
//  - FSM IDLE -> ISSUE -> WAIT_ACK -> IDLE. WAIT_ACK exits when port1_req==port1_ack, and
//    port2_req==port2_ack if port2 was issued. Flush+issue pairs pass through WAIT_ACK twice.
//  - ioctl_wait=1 from issue until FSM returns IDLE. ioctl_wr edges during wait: hps_io honours wait;
//    extras are dropped, not queued.
//  - PROM: addr>=PROM_BASE, index 0 -> dl_wr pulses 1 cycle, 1 cycle after edge; no SDRAM request.
//  - Index 1 -> core_mod<=dout. Index 254 with addr[24:3]==0 -> dsw byte addr[2:0]<=dout.
//  - Reset counter loads RST_CYCLES while reset|~rom_loaded, else decrements to 0.
//    core_reset = (count!=0), registered.
//  - Reset mid-download: pending dropped, FSM IDLE, toggles zeroed; sdram must be reset together.
//  - Address wrap: word addr = addr[23:1]; addr[24] ignored.
// STRUCTURE
//  - Package rom_dl_pkg: SPR_BASE/PROM_BASE defaults, index constants IDX_ROM=0, IDX_MOD=1, IDX_DIP=254.
//  - Package rom_dl_pkg also holds typedef fsm_t {IDLE,ISSUE,WAIT_ACK}.
//  - One sub-module, dl_word_packer: byte pairing and flush logic. FSM/handshake stay in top.
// TESTING
//  - Bytes 0x11@0, 0x22@1 -> one port1 req: a=0, ds=11, d=16'h2211; port2 untoggled.
//  - Bytes @0x30000/0x30001 -> port1 a=0x18000 and port2 a=0; ioctl_wait high until both acks
//    (ack delayed 5 cycles).
//  - Byte 0xAB@0x10 then @0x13 -> flush a=8 ds=01 d[7:0]=AB, then a=9 ds=10 d[15:8]=byte.
//  - Byte 0x5A@0xA0005 -> dl_wr one cycle, dl_addr=5, dl_data=5A; no port toggle.
//  - Odd-length download ending @0x7 even byte -> ds=01 flush before rom_loaded=1.
//    core_reset falls RST_CYCLES later.
//  - Index 254 byte 0x3C@2 -> dsw[23:16]=3C; @8 ignored. reset mid-WAIT_ACK -> all outputs at reset values.

Source files
------------

// File: rtl/rom_dl_pkg.sv
// Shared constants, FSM encoding and word-request record for the ROM download controller.
// Default region bases, ioctl index codes and the sprite-mirror address test.
package rom_dl_pkg;

  localparam logic [24:0] SPR_BASE_DEF   = 25'h30000;
  localparam logic [24:0] PROM_BASE_DEF  = 25'hA0000;
  localparam logic [15:0] RST_CYCLES_DEF = 16'hFFFF;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} fsm_t;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
    logic        mirror;
  } word_req_t;

  // Bases are even, so testing the even byte of a word decides for both bytes.
  function automatic logic in_sprite(input logic [22:0] wa,
                                     input logic [24:0] spr_base,
                                     input logic [24:0] prom_base);
    logic [24:0] byte_a;
    byte_a = {1'b0, wa, 1'b0};
    return (byte_a >= spr_base) && (byte_a < prom_base);
  endfunction

endpackage

// File: rtl/dl_word_packer.sv
// Pairs ROM bytes into 16-bit write requests; latency 1 cycle from accepted byte to out_vld.
// Backpressure: holds up to two requests (flush + issue); caller only offers bytes when out_vld is low.
module dl_word_packer
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] SPR_BASE  = SPR_BASE_DEF,
  parameter logic [24:0] PROM_BASE = PROM_BASE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        byte_vld,
  input  logic [23:0] byte_addr,
  input  logic [7:0]  byte_dat,
  input  logic        flush_vld,
  output logic        pend,
  output logic        out_vld,
  output logic [22:0] out_a,
  output logic [1:0]  out_ds,
  output logic [15:0] out_d,
  output logic        out_mirror,
  input  logic        out_rdy
);

  logic        pend_q;
  logic [7:0]  lo_q;
  logic [22:0] waddr_q;
  logic        slot1_vld;
  word_req_t   slot0, slot1;
  word_req_t   flush_req, full_req, hi_req;
  logic        same_word;

  assign same_word = pend_q && (waddr_q == byte_addr[23:1]);

  always_comb begin
    flush_req.a      = waddr_q;
    flush_req.ds     = 2'b01;
    flush_req.d      = {8'h00, lo_q};
    flush_req.mirror = in_sprite(waddr_q, SPR_BASE, PROM_BASE);

    full_req.a       = waddr_q;
    full_req.ds      = 2'b11;
    full_req.d       = {byte_dat, lo_q};
    full_req.mirror  = flush_req.mirror;

    hi_req.a         = byte_addr[23:1];
    hi_req.ds        = 2'b10;
    hi_req.d         = {byte_dat, 8'h00};
    hi_req.mirror    = in_sprite(byte_addr[23:1], SPR_BASE, PROM_BASE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_q    <= 1'b0;
      lo_q      <= '0;
      waddr_q   <= '0;
      out_vld   <= 1'b0;
      slot0     <= '0;
      slot1_vld <= 1'b0;
      slot1     <= '0;
    end else begin
      if (out_rdy) begin
        out_vld   <= slot1_vld;
        slot0     <= slot1;
        slot1_vld <= 1'b0;
      end
      if (byte_vld) begin
        if (!byte_addr[0]) begin
          // A new even byte always displaces whatever was pending.
          if (pend_q) begin
            out_vld <= 1'b1;
            slot0   <= flush_req;
          end
          pend_q  <= 1'b1;
          lo_q    <= byte_dat;
          waddr_q <= byte_addr[23:1];
        end else if (same_word) begin
          out_vld <= 1'b1;
          slot0   <= full_req;
          pend_q  <= 1'b0;
        end else if (pend_q) begin
          out_vld   <= 1'b1;
          slot0     <= flush_req;
          slot1_vld <= 1'b1;
          slot1     <= hi_req;
          pend_q    <= 1'b0;
        end else begin
          out_vld <= 1'b1;
          slot0   <= hi_req;
        end
      end else if (flush_vld && pend_q) begin
        out_vld <= 1'b1;
        slot0   <= flush_req;
        pend_q  <= 1'b0;
      end
    end
  end

  assign pend       = pend_q;
  assign out_a      = slot0.a;
  assign out_ds     = slot0.ds;
  assign out_d      = slot0.d;
  assign out_mirror = slot0.mirror;

endmodule

// File: rtl/rom_dl_ctrl.sv
// ioctl download front end: SDRAM word writes (port2 mirrors sprites), PROM/DIP/mod routing, core reset.
// Latency: request toggles 3 cycles after the byte edge; ioctl_wait holds hps_io until all acks return.
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter logic [24:0] SPR_BASE   = SPR_BASE_DEF,
  parameter logic [24:0] PROM_BASE  = PROM_BASE_DEF,
  parameter logic [15:0] RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        dl_wr,
  output logic [7:0]  core_mod,
  output logic [63:0] dsw,
  output logic        rom_loaded,
  output logic        core_reset
);

  fsm_t        state, state_nxt;
  logic        wr_q, dl_q, wr_rise, dl_fall, is_rom, busy;
  logic        rom_byte, prom_byte, flush_vld, end_pend, p2_issued, acks_done;
  logic        pk_pend, pk_vld, pk_mirror, pk_rdy;
  logic [22:0] pk_a;
  logic [1:0]  pk_ds;
  logic [15:0] pk_d, cnt, cnt_nxt;

  assign wr_rise    = ioctl_wr & ~wr_q;
  assign dl_fall    = dl_q & ~ioctl_download;
  assign is_rom     = (ioctl_index == IDX_ROM);
  assign busy       = (state != IDLE) | pk_vld;
  assign ioctl_wait = busy;
  assign rom_byte   = wr_rise & is_rom & (ioctl_addr < PROM_BASE) & ~busy;
  assign prom_byte  = wr_rise & is_rom & (ioctl_addr >= PROM_BASE);
  assign flush_vld  = end_pend & ~busy;
  assign acks_done  = (port1_req == port1_ack) & (~p2_issued | (port2_req == port2_ack));

  dl_word_packer #(.SPR_BASE(SPR_BASE), .PROM_BASE(PROM_BASE)) u_packer (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .byte_vld   (rom_byte),
    .byte_addr  (ioctl_addr[23:0]),
    .byte_dat   (ioctl_dout),
    .flush_vld  (flush_vld),
    .pend       (pk_pend),
    .out_vld    (pk_vld),
    .out_a      (pk_a),
    .out_ds     (pk_ds),
    .out_d      (pk_d),
    .out_mirror (pk_mirror),
    .out_rdy    (pk_rdy)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pk_rdy    = 1'b0;
    case (state)
      IDLE:     if (pk_vld) state_nxt = ISSUE;
      ISSUE: begin
        pk_rdy    = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: if (acks_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
      p2_issued <= 1'b0;
    end else if (state == ISSUE) begin
      port1_req <= ~port1_req;
      port1_a   <= pk_a;
      port1_ds  <= pk_ds;
      port1_d   <= pk_d;
      p2_issued <= pk_mirror;
      if (pk_mirror) begin
        port2_req <= ~port2_req;
        port2_a   <= pk_a - SPR_BASE[23:1];
        port2_ds  <= pk_ds;
        port2_d   <= pk_d;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      dl_wr      <= 1'b0;
      dl_addr    <= '0;
      dl_data    <= '0;
      core_mod   <= '0;
      dsw        <= '1;
      rom_loaded <= 1'b0;
      end_pend   <= 1'b0;
    end else begin
      wr_q  <= ioctl_wr;
      dl_q  <= ioctl_download;
      dl_wr <= prom_byte;
      if (prom_byte) begin
        dl_addr <= ioctl_addr[15:0] - PROM_BASE[15:0];
        dl_data <= ioctl_dout;
      end
      if (wr_rise && ioctl_index == IDX_MOD) core_mod <= ioctl_dout;
      if (wr_rise && ioctl_index == IDX_DIP && ioctl_addr[24:3] == '0)
        dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      // rom_loaded waits for any odd trailing byte to be flushed and acked.
      if (dl_fall && is_rom) end_pend <= 1'b1;
      else if (end_pend && !busy && !pk_pend) begin
        end_pend   <= 1'b0;
        rom_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    cnt_nxt = RST_CYCLES;
    if (rom_loaded) cnt_nxt = (cnt != '0) ? cnt - 16'd1 : '0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt        <= RST_CYCLES;
      core_reset <= 1'b1;
    end else begin
      cnt        <= cnt_nxt;
      core_reset <= (cnt_nxt != '0);
    end
  end

endmodule
